// File: rtl/rgb565_stream_decoder.sv
// Byte-stream to pixel decoder: reassembles big-endian RGB565 pixels, expands them to RGB888
// and tags frame/line markers. Optional macro RGB565_REPLICATE_EN selects MSB-replication fill.
module rgb565_stream_decoder #(
    parameter int IM_X = 1280,
    parameter int IM_Y = 720
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       frame_start,
    input  logic       out_ready,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       pixel_valid,
    output logic       sof,
    output logic       eol,
    output logic       eof,
    output logic       frame_err
);

    localparam int XW = (IM_X > 1) ? $clog2(IM_X) : 1;
    localparam int YW = (IM_Y > 1) ? $clog2(IM_Y) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IM_X - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IM_Y - 1);
    localparam logic [XW-1:0] X_ZERO = {XW{1'b0}};
    localparam logic [YW-1:0] Y_ZERO = {YW{1'b0}};

    typedef enum logic [0:0] {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_t;

    function automatic logic [7:0] expand5(input logic [4:0] v);
`ifdef RGB565_REPLICATE_EN
        expand5 = {v, v[4:2]};
`else
        expand5 = {v, 3'b000};
`endif
    endfunction

    function automatic logic [7:0] expand6(input logic [5:0] v);
`ifdef RGB565_REPLICATE_EN
        expand6 = {v, v[5:4]};
`else
        expand6 = {v, 2'b00};
`endif
    endfunction

    phase_t        phase_q, phase_d;
    logic [7:0]    hold_q, hold_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    r_q, r_d;
    logic [7:0]    g_q, g_d;
    logic [7:0]    b_q, b_d;
    logic          pv_q, pv_d;
    logic          sof_q, sof_d;
    logic          eol_q, eol_d;
    logic          eof_q, eof_d;
    logic          err_q, err_d;

    logic          accept_s;
    logic          pixel_done_s;
    logic          x_last_s;
    logic          y_last_s;
    logic [4:0]    r5_s;
    logic [5:0]    g6_s;
    logic [4:0]    b5_s;

    // The output stage frees up when empty or when its pixel is being taken this cycle.
    assign byte_ready = !pv_q | out_ready;
    assign accept_s   = byte_valid & byte_ready;
    assign x_last_s   = (x_q == X_LAST);
    assign y_last_s   = (y_q == Y_LAST);
    assign r5_s       = hold_q[7:3];
    assign g6_s       = {hold_q[2:0], byte_in[7:5]};
    assign b5_s       = byte_in[4:0];

    // Phase FSM, hold register, position counters and frame-boundary checking.
    always_comb begin
        phase_d      = phase_q;
        hold_d       = hold_q;
        x_d          = x_q;
        y_d          = y_q;
        err_d        = 1'b0;
        pixel_done_s = 1'b0;
        if (accept_s) begin
            if (frame_start) begin
                // Always restarts as a HI byte; any half pixel or partial frame is dropped.
                hold_d  = byte_in;
                phase_d = PH_LO;
                x_d     = X_ZERO;
                y_d     = Y_ZERO;
                err_d   = (phase_q == PH_LO) || (x_q != X_ZERO) || (y_q != Y_ZERO);
            end else begin
                case (phase_q)
                    PH_HI: begin
                        hold_d  = byte_in;
                        phase_d = PH_LO;
                    end
                    PH_LO: begin
                        phase_d      = PH_HI;
                        pixel_done_s = 1'b1;
                        if (x_last_s) begin
                            x_d = X_ZERO;
                            if (y_last_s) begin
                                y_d = Y_ZERO;
                            end else begin
                                y_d = y_q + 1'b1;
                            end
                        end else begin
                            x_d = x_q + 1'b1;
                            y_d = y_q;
                        end
                    end
                    default: begin
                        phase_d = PH_HI;
                    end
                endcase
            end
        end else begin
            phase_d = phase_q;
        end
    end

    // Output register: load on pixel completion, clear once taken, hold under backpressure.
    always_comb begin
        r_d   = r_q;
        g_d   = g_q;
        b_d   = b_q;
        pv_d  = pv_q;
        sof_d = sof_q;
        eol_d = eol_q;
        eof_d = eof_q;
        if (pixel_done_s) begin
            r_d   = expand5(r5_s);
            g_d   = expand6(g6_s);
            b_d   = expand5(b5_s);
            pv_d  = 1'b1;
            sof_d = (x_q == X_ZERO) && (y_q == Y_ZERO);
            eol_d = x_last_s;
            eof_d = x_last_s && y_last_s;
        end else if (out_ready) begin
            pv_d = 1'b0;
        end else begin
            pv_d = pv_q;
        end
    end

    // State and output flops with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= PH_HI;
            hold_q  <= 8'h00;
            x_q     <= X_ZERO;
            y_q     <= Y_ZERO;
            r_q     <= 8'h00;
            g_q     <= 8'h00;
            b_q     <= 8'h00;
            pv_q    <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            hold_q  <= hold_d;
            x_q     <= x_d;
            y_q     <= y_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            pv_q    <= pv_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
            eof_q   <= eof_d;
            err_q   <= err_d;
        end
    end

    assign R           = r_q;
    assign G           = g_q;
    assign B           = b_q;
    assign pixel_valid = pv_q;
    assign sof         = sof_q;
    assign eol         = eol_q;
    assign eof         = eof_q;
    assign frame_err   = err_q;

endmodule

// File: tb/tb_rgb565_stream_decoder.sv
// Scoreboard bench for rgb565_stream_decoder on a 4x2 frame; honours RGB565_REPLICATE_EN.
module tb_rgb565_stream_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       frame_start;
    logic       out_ready;
    logic [7:0] R, G, B;
    logic       pixel_valid, sof, eol, eof, frame_err;

`ifdef RGB565_REPLICATE_EN
    localparam logic [7:0] F5 = 8'hFF;
    localparam logic [7:0] F6 = 8'hFF;
`else
    localparam logic [7:0] F5 = 8'hF8;
    localparam logic [7:0] F6 = 8'hFC;
`endif

    typedef struct {
        logic [23:0] rgb;
        logic [2:0]  mk;   // {sof, eol, eof}
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   err_seen = 0;

    rgb565_stream_decoder #(.IM_X(4), .IM_Y(2)) dut (
        .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .frame_start(frame_start), .out_ready(out_ready),
        .R(R), .G(G), .B(B), .pixel_valid(pixel_valid), .sof(sof), .eol(eol),
        .eof(eof), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a pixel is transferred at the edge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (!rst && pixel_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_pixel", {R, G, B}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("pixel_rgb", {R, G, B}, e.rgb);
                check("pixel_markers", {sof, eol, eof}, e.mk);
            end
        end
        if (!rst && frame_err) err_seen++;
    end

    task automatic push(input logic [23:0] rgb, input logic [2:0] mk);
        exp_t e;
        e.rgb = rgb;
        e.mk  = mk;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b, input logic fs);
        int n;
        n = 0;
        byte_in = b; byte_valid = 1'b1; frame_start = fs;
        while (!byte_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!byte_ready) check("byte_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic send_px(input logic [7:0] hi, input logic [7:0] lo, input logic fs,
                           input logic [23:0] rgb, input logic [2:0] mk);
        send(hi, fs);
        push(rgb, mk);
        send(lo, 1'b0);
        check("pixel_latency", {31'd0, pixel_valid}, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1; byte_valid = 1'b0; frame_start = 1'b0; byte_in = 8'h00; out_ready = 1'b1;
        #1;
        check("reset_rgb", {R, G, B}, 32'd0);
        check("reset_flags", {pixel_valid, sof, eol, eof, frame_err}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic finish_test(input string name, input int err_before, input int err_exp);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_drained"}, q.size(), 32'd0);
        check({name, "_frame_err"}, err_seen - err_before, err_exp);
        q.delete();
    endtask

    initial begin
        int e0;
        logic [23:0] pat[4];
        logic [7:0]  phi[4];
        logic [7:0]  plo[4];
        pat[0] = {F5, 8'h00, 8'h00}; phi[0] = 8'hF8; plo[0] = 8'h00;
        pat[1] = {8'h00, F6, 8'h00}; phi[1] = 8'h07; plo[1] = 8'hE0;
        pat[2] = {8'h00, 8'h00, F5}; phi[2] = 8'h00; plo[2] = 8'h1F;
        pat[3] = {F5, F6, F5};       phi[3] = 8'hFF; plo[3] = 8'hFF;

        // Basic decode
        do_reset();
        check("idle_byte_ready", {31'd0, byte_ready}, 32'd1);
        e0 = err_seen;
        send_px(8'hF8, 8'h00, 1'b1, {F5, 8'h00, 8'h00}, 3'b100);
        send_px(8'h07, 8'hE0, 1'b0, {8'h00, F6, 8'h00}, 3'b000);
        send_px(8'h00, 8'h1F, 1'b0, {8'h00, 8'h00, F5}, 3'b000);
        finish_test("basic", e0, 0);

        // Markers over a full frame plus wrap into the next
        do_reset();
        e0 = err_seen;
        for (int i = 0; i < 9; i++) begin
            logic [2:0] mk;
            mk = {(i == 0 || i == 8), (i == 3 || i == 7), (i == 7)};
            send_px(phi[i % 4], plo[i % 4], (i == 0), pat[i % 4], mk);
        end
        finish_test("markers", e0, 0);

        // Backpressure
        do_reset();
        e0 = err_seen;
        out_ready = 1'b0;
        send_px(8'hF8, 8'h00, 1'b1, {F5, 8'h00, 8'h00}, 3'b100);
        byte_in = 8'h07; byte_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_byte_ready", {31'd0, byte_ready}, 32'd0);
            check("bp_hold_rgb", {R, G, B}, {F5, 16'h0000});
            check("bp_hold_valid", {31'd0, pixel_valid}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_resume_ready", {31'd0, byte_ready}, 32'd1);
        @(posedge clk); #1;
        byte_valid = 1'b0;
        push({8'h00, F6, 8'h00}, 3'b000);
        send(8'hE0, 1'b0);
        finish_test("backpressure", e0, 0);

        // Orphaned HI byte
        do_reset();
        e0 = err_seen;
        send(8'hAA, 1'b1);
        send(8'hF8, 1'b1);
        check("orphan_err_pulse", {31'd0, frame_err}, 32'd1);
        push({F5, 8'h00, 8'h00}, 3'b100);
        send(8'h00, 1'b0);
        check("orphan_err_cleared", {31'd0, frame_err}, 32'd0);
        finish_test("orphan", e0, 1);

        // Partial frame
        do_reset();
        e0 = err_seen;
        for (int i = 0; i < 3; i++)
            send_px(phi[i], plo[i], (i == 0), pat[i], (i == 0) ? 3'b100 : 3'b000);
        send(8'h00, 1'b1);
        check("partial_err_pulse", {31'd0, frame_err}, 32'd1);
        push({8'h00, 8'h00, F5}, 3'b100);
        send(8'h1F, 1'b0);
        finish_test("partial", e0, 1);

        // Reset mid-pixel
        do_reset();
        send(8'hF8, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_rgb", {R, G, B}, 32'd0);
        check("midrst_flags", {pixel_valid, sof, eol, eof, frame_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        e0 = err_seen;
        send(8'h00, 1'b0);
        push({8'h00, 8'h00, F5}, 3'b100);
        send(8'h1F, 1'b0);
        finish_test("midreset", e0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
